multi_cycle_controller: RTL and testbench
=========================================

// Module: multi_cycle_controller
// PURPOSE
//  Multi-cycle MIPS control FSM; successor to the single-cycle decoder. Sequences FETCH/DECODE/EXEC/MEM/WB
//  over one shared memory port with a req/ready handshake. Extended ISA: addu subu slt jr syscall ori addiu
//  lw sw beq bne lui j jal. Adds a memory-timeout watchdog and a retired-instruction counter. Drives the datapath.
// PARAMETERS
//  MEM_HANDSHAKE  1   1: wait on mem_ready; 0: memory completes in one cycle, mem_ready ignored
//  MEM_TIMEOUT    15  max wait cycles per access before mem_error (4-bit min, 1..255)
//  CNT_W          32  width of retired_count
// PORTS
//  clk              in   1      rising-edge clock
//  rst              in   1      asynchronous, active-high reset
//  opcode / funct   in   6/6    IR[31:26] / IR[5:0], valid from DECODE onward
//  alu_zero         in   1      ALU zero flag (branch compare)
//  mem_ready        in   1      memory completes current access this cycle
//  pc_write         out  1      load PC
//  pc_src           out  2      0 ALU(PC+4), 1 ALUOut(branch target), 2 jump target, 3 rs (jr)
//  ir_write         out  1      load IR
//  iord             out  1      0 address=PC, 1 address=ALUOut
//  mem_req / mem_we out  1/1    access request (held until ready) / write qualifier
//  reg_write        out  1      RF write strobe
//  reg_dst_sel      out  2      0 rt, 1 rd, 2 $31
//  wb_sel           out  2      0 ALUOut, 1 MDR, 2 PC, 3 {imm,16'b0}
//  alu_src_a        out  1      0 PC, 1 rs
//  alu_src_b        out  2      0 rt, 1 const 4, 2 ext imm, 3 sext imm<<2
//  use_zero_extend  out  1      immediate zero-extension
//  alu_control      out  4      `ALU_CTRL_* encoding
//  halt / mem_error out  1/1    sticky; set on syscall / timeout
//  illegal          out  1      one-cycle pulse, unknown opcode/funct
//  retired_count    out  CNT_W  instructions completed, wraps to 0
// BEHAVIOUR
//  - Reset: state=FETCH, wait_cnt=0, retired_count=0, halt=mem_error=0. While rst=1 every output is 0.
//  - Outputs are Moore (decoded from state) except pc_write in BRANCH (condition on alu_zero) and FETCH/mem
//    strobes, which qualify on mem_ready.
//  - FETCH: mem_req=1,iord=0,alu_src_a=0,alu_src_b=1,ADD. On ready: ir_write=1,pc_write=1,pc_src=0 -> DECODE.
//  - DECODE: ALUOut<=PC+(sext imm<<2) (alu_src_b=3, ADD). Next: R->EXEC_R; jr->JR; syscall->HALT;
//    ori/addiu/lui->EXEC_I; lw/sw->MEM_ADDR; beq/bne->BRANCH; j/jal->JUMP; else illegal=1 -> FETCH.
//  - EXEC_R (alu_src_a=1,b=0; ADD/SUB/SLT) -> WB_ALU (reg_dst=rd). EXEC_I (b=2; OR zext / ADD sext /
//    PASS) -> WB_ALU (reg_dst=rt; lui uses wb_sel=3).
//  - MEM_ADDR (ADD sext) -> MEM_RD (lw) | MEM_WR (sw). MEM_RD: mem_req,iord=1 until ready -> WB_MEM (wb_sel=1).
//    MEM_WR: mem_req,mem_we,iord=1 until ready -> FETCH.
//  - BRANCH: SUB rs,rt; pc_write=(beq ? alu_zero : ~alu_zero), pc_src=1 -> FETCH.
//  - JUMP: pc_write,pc_src=2; jal also reg_write,reg_dst=2,wb_sel=2 (PC already +4) -> FETCH. JR: pc_src=3.
//  - Latency (zero wait): branch/j/jal/jr 3 cycles, R/I 4, sw 4, lw 5; each wait cycle adds one.
//  - wait_cnt clears on entry to a memory state, increments per cycle with mem_ready=0; reaching
//    MEM_TIMEOUT -> mem_error=1, HALT. MEM_HANDSHAKE=0: ready treated as 1, no timeout.
//  - retired_count +1 on every transition into FETCH from a non-DECODE state (illegal does not retire).
//  - HALT: all strobes 0, absorbing until rst. Reset mid-access drops mem_req asynchronously.
//  - Decoding keeps rs/rt/rd/imm out of scope: datapath owns fields; this block sees opcode/funct only.
// STRUCTURE
//  - cpu_defs.vh: ST_* 4-bit state encodings, OPC_*/FUNCT_* codes, PCSRC_*/WB_*/DST_* selects,
//    `ALU_CTRL_* (add SLT if absent).
//  - Sub-module alu_op_decode: combinational {state,opcode,funct} -> alu_control, use_zero_extend.
//  - Top: state register, next-state logic, wait_cnt, retired_count, sticky flags.
// TESTING
//  - addu after reset, ready=1: FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1,reg_dst_sel=1 in cycle 4; count=1.
//  - lw with ready low 3 cycles in MEM_RD: mem_req,iord held 3+1 cycles; WB_MEM wb_sel=1; total 8 cycles.
//  - beq alu_zero=1 -> pc_write=1,pc_src=1; bne alu_zero=1 -> pc_write=0; both retire in 3 cycles.
//  - MEM_TIMEOUT=4, ready stuck 0 in FETCH -> mem_error=1 at wait 4, HALT, outputs 0 until rst.
//  - opcode 6'h3f -> illegal pulse 1 cycle, back to FETCH, count unchanged; syscall -> halt=1 sticky.
//  - CNT_W=4: 16 retired addu -> count wraps to 0; rst mid MEM_WR -> mem_we drops same cycle, FETCH after.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct values, datapath select encodings and ALU control codes.
package multi_cycle_controller_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_WB_ALU   = 4'd4,
      ST_MEM_ADDR = 4'd5,
      ST_MEM_RD   = 4'd6,
      ST_MEM_WR   = 4'd7,
      ST_WB_MEM   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10,
      ST_JR       = 4'd11,
      ST_HALT     = 4'd12
   } state_t;

   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_ORI   = 6'h0d;
   localparam logic [5:0] OPC_LUI   = 6'h0f;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2b;

   localparam logic [5:0] FUNCT_JR      = 6'h08;
   localparam logic [5:0] FUNCT_SYSCALL = 6'h0c;
   localparam logic [5:0] FUNCT_ADDU    = 6'h21;
   localparam logic [5:0] FUNCT_SUBU    = 6'h23;
   localparam logic [5:0] FUNCT_SLT     = 6'h2a;

   localparam logic [1:0] PCSRC_PC4  = 2'd0;
   localparam logic [1:0] PCSRC_BR   = 2'd1;
   localparam logic [1:0] PCSRC_JUMP = 2'd2;
   localparam logic [1:0] PCSRC_RS   = 2'd3;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;
   localparam logic [1:0] WB_UPPER  = 2'd3;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic       ALUA_PC = 1'b0;
   localparam logic       ALUA_RS = 1'b1;

   localparam logic [1:0] ALUB_RT   = 2'd0;
   localparam logic [1:0] ALUB_FOUR = 2'd1;
   localparam logic [1:0] ALUB_IMM  = 2'd2;
   localparam logic [1:0] ALUB_BR   = 2'd3;

   localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
   localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
   localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
   localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
   localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
   localparam logic [3:0] ALU_CTRL_PASS = 4'b1000;

   // Strobes and selects decoded from state; zeroed as a group in reset.
   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       iord;
      logic       mem_req;
      logic       mem_we;
      logic       reg_write;
      logic [1:0] reg_dst_sel;
      logic [1:0] wb_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_op_decode.sv
// ALU operation decode: {state, opcode, funct} -> alu_control and
// immediate zero-extend select. Purely combinational.
module alu_op_decode
   import multi_cycle_controller_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_control_o,
   output logic       use_zero_extend_o
);

   always_comb begin
      alu_control_o     = ALU_CTRL_ADD;
      use_zero_extend_o = 1'b0;
      case (state_i)
         ST_EXEC_R: begin
            if (funct_i == FUNCT_SUBU) begin
               alu_control_o = ALU_CTRL_SUB;
            end else if (funct_i == FUNCT_SLT) begin
               alu_control_o = ALU_CTRL_SLT;
            end
         end
         ST_EXEC_I: begin
            if (opcode_i == OPC_ORI) begin
               alu_control_o     = ALU_CTRL_OR;
               use_zero_extend_o = 1'b1;
            end else if (opcode_i == OPC_LUI) begin
               alu_control_o = ALU_CTRL_PASS;
            end
         end
         ST_BRANCH: alu_control_o = ALU_CTRL_SUB;
         ST_HALT:   alu_control_o = ALU_CTRL_AND;
         default:   alu_control_o = ALU_CTRL_ADD;
      endcase
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM sharing one memory port (req/ready).
// Ports: clk/rst, opcode/funct/alu_zero/mem_ready in; datapath strobes,
// selects, alu_control, halt/mem_error/illegal flags, retired_count out.
module multi_cycle_controller
   import multi_cycle_controller_pkg::*;
#(
   parameter int MEM_HANDSHAKE = 1,
   parameter int MEM_TIMEOUT   = 15,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_req,
   output logic             mem_we,
   output logic             reg_write,
   output logic [1:0]       reg_dst_sel,
   output logic [1:0]       wb_sel,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             use_zero_extend,
   output logic [3:0]       alu_control,
   output logic             halt,
   output logic             mem_error,
   output logic             illegal,
   output logic [CNT_W-1:0] retired_count
);

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halt_q, halt_d;
   logic             err_q, err_d;

   logic  ready;
   logic  op_r, r_alu, r_jr, r_sys;
   logic  op_imm, op_mem, op_br, op_jmp;
   ctrl_t c;
   logic [3:0] alu_ctrl_w;
   logic       zext_w;

   // Without handshake every access completes in its first cycle.
   assign ready = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   assign op_r   = (opcode == OPC_RTYPE);
   assign r_alu  = op_r && ((funct == FUNCT_ADDU) ||
                            (funct == FUNCT_SUBU) ||
                            (funct == FUNCT_SLT));
   assign r_jr   = op_r && (funct == FUNCT_JR);
   assign r_sys  = op_r && (funct == FUNCT_SYSCALL);
   assign op_imm = (opcode == OPC_ORI) || (opcode == OPC_ADDIU) ||
                   (opcode == OPC_LUI);
   assign op_mem = (opcode == OPC_LW) || (opcode == OPC_SW);
   assign op_br  = (opcode == OPC_BEQ) || (opcode == OPC_BNE);
   assign op_jmp = (opcode == OPC_J) || (opcode == OPC_JAL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         wait_q  <= '0;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         halt_q  <= halt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      cnt_d   = cnt_q;
      halt_d  = halt_q;
      err_d   = err_q;

      unique case (state_q)
         ST_FETCH: begin
            if (ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (r_alu) begin
               state_d = ST_EXEC_R;
            end else if (r_jr) begin
               state_d = ST_JR;
            end else if (r_sys) begin
               state_d = ST_HALT;
               halt_d  = 1'b1;
            end else if (op_imm) begin
               state_d = ST_EXEC_I;
            end else if (op_mem) begin
               state_d = ST_MEM_ADDR;
            end else if (op_br) begin
               state_d = ST_BRANCH;
            end else if (op_jmp) begin
               state_d = ST_JUMP;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
         ST_MEM_ADDR: begin
            state_d = (opcode == OPC_LW) ? ST_MEM_RD : ST_MEM_WR;
         end
         ST_MEM_RD: begin
            if (ready) state_d = ST_WB_MEM;
         end
         ST_MEM_WR: begin
            if (ready) state_d = ST_FETCH;
         end
         ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_JR: begin
            state_d = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase

      // Watchdog: counts stalled cycles of the current access.
      if (is_mem_state(state_q) && !ready) begin
         wait_d = wait_q + 8'd1;
         if (wait_d == TMO) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
         end
      end

      if ((state_d != state_q) && is_mem_state(state_d)) begin
         wait_d = '0;
      end

      // DECODE -> FETCH is the illegal path and does not retire.
      if ((state_d == ST_FETCH) && (state_q != ST_FETCH) &&
          (state_q != ST_DECODE)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      c = '0;
      unique case (state_q)
         ST_FETCH: begin
            c.mem_req   = 1'b1;
            c.iord      = 1'b0;
            c.alu_src_a = ALUA_PC;
            c.alu_src_b = ALUB_FOUR;
            if (ready) begin
               c.ir_write = 1'b1;
               c.pc_write = 1'b1;
               c.pc_src   = PCSRC_PC4;
            end
         end
         ST_DECODE: begin
            c.alu_src_a = ALUA_PC;
            c.alu_src_b = ALUB_BR;
            c.illegal   = !(r_alu || r_jr || r_sys || op_imm ||
                            op_mem || op_br || op_jmp);
         end
         ST_EXEC_R: begin
            c.alu_src_a = ALUA_RS;
            c.alu_src_b = ALUB_RT;
         end
         ST_EXEC_I, ST_MEM_ADDR: begin
            c.alu_src_a = ALUA_RS;
            c.alu_src_b = ALUB_IMM;
         end
         ST_WB_ALU: begin
            c.reg_write   = 1'b1;
            c.reg_dst_sel = op_r ? DST_RD : DST_RT;
            c.wb_sel      = (opcode == OPC_LUI) ? WB_UPPER : WB_ALUOUT;
         end
         ST_MEM_RD: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
         end
         ST_MEM_WR: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.iord    = 1'b1;
         end
         ST_WB_MEM: begin
            c.reg_write   = 1'b1;
            c.reg_dst_sel = DST_RT;
            c.wb_sel      = WB_MDR;
         end
         ST_BRANCH: begin
            c.alu_src_a = ALUA_RS;
            c.alu_src_b = ALUB_RT;
            c.pc_src    = PCSRC_BR;
            c.pc_write  = (opcode == OPC_BEQ) ? alu_zero : ~alu_zero;
         end
         ST_JUMP: begin
            c.pc_write = 1'b1;
            c.pc_src   = PCSRC_JUMP;
            if (opcode == OPC_JAL) begin
               c.reg_write   = 1'b1;
               c.reg_dst_sel = DST_RA;
               c.wb_sel      = WB_PC;
            end
         end
         ST_JR: begin
            c.pc_write = 1'b1;
            c.pc_src   = PCSRC_RS;
         end
         ST_HALT: c = '0;
         default: c = '0;
      endcase
      // Reset kills any in-flight access without waiting for a clock.
      if (rst) c = '0;
   end

   alu_op_decode u_alu_op_decode (
      .state_i           (state_q),
      .opcode_i          (opcode),
      .funct_i           (funct),
      .alu_control_o     (alu_ctrl_w),
      .use_zero_extend_o (zext_w)
   );

   assign pc_write        = c.pc_write;
   assign pc_src          = c.pc_src;
   assign ir_write        = c.ir_write;
   assign iord            = c.iord;
   assign mem_req         = c.mem_req;
   assign mem_we          = c.mem_we;
   assign reg_write       = c.reg_write;
   assign reg_dst_sel     = c.reg_dst_sel;
   assign wb_sel          = c.wb_sel;
   assign alu_src_a       = c.alu_src_a;
   assign alu_src_b       = c.alu_src_b;
   assign illegal         = c.illegal;
   assign alu_control     = rst ? 4'd0 : alu_ctrl_w;
   assign use_zero_extend = rst ? 1'b0 : zext_w;
   assign halt            = halt_q;
   assign mem_error       = err_q;
   assign retired_count   = cnt_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller (MEM_TIMEOUT=4, CNT_W=4).
// Inputs change just after the falling edge, outputs are checked 1 ns later.
module tb_multi_cycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic       alu_zero, mem_ready;
   logic       pc_write, ir_write, iord, mem_req, mem_we, reg_write;
   logic [1:0] pc_src, reg_dst_sel, wb_sel, alu_src_b;
   logic       alu_src_a, use_zero_extend, halt, mem_error, illegal;
   logic [3:0] alu_control, retired_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [3:0]  exp_cnt;
   logic [31:0] got, want;

   always #5 clk = ~clk;

   multi_cycle_controller #(
      .MEM_HANDSHAKE (1),
      .MEM_TIMEOUT   (4),
      .CNT_W         (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .opcode          (opcode),
      .funct           (funct),
      .alu_zero        (alu_zero),
      .mem_ready       (mem_ready),
      .pc_write        (pc_write),
      .pc_src          (pc_src),
      .ir_write        (ir_write),
      .iord            (iord),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .reg_write       (reg_write),
      .reg_dst_sel     (reg_dst_sel),
      .wb_sel          (wb_sel),
      .alu_src_a       (alu_src_a),
      .alu_src_b       (alu_src_b),
      .use_zero_extend (use_zero_extend),
      .alu_control     (alu_control),
      .halt            (halt),
      .mem_error       (mem_error),
      .illegal         (illegal),
      .retired_count   (retired_count)
   );

   task automatic next_cycle;
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
      exp_cnt = 4'd0;
   endtask

   task automatic test_reset;
      rst = 1'b1; opcode = 6'h00; funct = 6'h00;
      alu_zero = 1'b0; mem_ready = 1'b1;
      next_cycle();
      #1;
      got = 32'({pc_write, pc_src, ir_write, iord, mem_req, mem_we,
                 reg_write, reg_dst_sel, wb_sel, alu_src_a, alu_src_b,
                 use_zero_extend, alu_control, halt, mem_error, illegal,
                 retired_count});
      want = 32'd0;
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL reset_outputs got=%h want=%h", got, want);
      end
      next_cycle();
      rst = 1'b0;
      exp_cnt = 4'd0;
      #1;
      got = 32'({mem_req, iord, alu_src_b, alu_control});
      want = 32'({1'b1, 1'b0, 2'd1, 4'b0010});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL reset_fetch got=%h want=%h", got, want);
      end
   endtask

   task automatic test_addu;
      opcode = 6'h00; funct = 6'h21; mem_ready = 1'b1;
      #1;
      got = 32'({mem_req, ir_write, pc_write, pc_src, iord});
      want = 32'({1'b1, 1'b1, 1'b1, 2'd0, 1'b0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL addu_fetch got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      got = 32'({mem_req, alu_src_a, alu_src_b, alu_control});
      want = 32'({1'b0, 1'b0, 2'd3, 4'b0010});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL addu_decode got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      got = 32'({alu_src_a, alu_src_b, alu_control, reg_write});
      want = 32'({1'b1, 2'd0, 4'b0010, 1'b0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL addu_exec got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      got = 32'({reg_write, reg_dst_sel, wb_sel});
      want = 32'({1'b1, 2'd1, 2'd0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL addu_wb got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      exp_cnt = exp_cnt + 4'd1;
      got = 32'({mem_req, retired_count});
      want = 32'({1'b1, exp_cnt});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL addu_retire got=%h want=%h", got, want);
      end
   endtask

   task automatic test_lw_wait;
      opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
      #1;
      next_cycle(); #1;
      next_cycle(); #1;
      got = 32'({alu_src_a, alu_src_b, alu_control, mem_req});
      want = 32'({1'b1, 2'd2, 4'b0010, 1'b0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL lw_addr got=%h want=%h", got, want);
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         mem_ready = (i == 3);
         #1;
         got = 32'({mem_req, iord, mem_we, reg_write});
         want = 32'({1'b1, 1'b1, 1'b0, 1'b0});
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL lw_memrd%0d got=%h want=%h", i, got, want);
         end
      end
      next_cycle(); #1;
      got = 32'({reg_write, reg_dst_sel, wb_sel, mem_req});
      want = 32'({1'b1, 2'd0, 2'd1, 1'b0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL lw_wbmem got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      exp_cnt = exp_cnt + 4'd1;
      got = 32'({mem_req, iord, retired_count});
      want = 32'({1'b1, 1'b0, exp_cnt});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL lw_retire got=%h want=%h", got, want);
      end
   endtask

   task automatic test_branch;
      for (int k = 0; k < 3; k++) begin
         opcode = (k == 1) ? 6'h05 : 6'h04;
         alu_zero = (k != 2);
         mem_ready = 1'b1;
         #1;
         next_cycle(); #1;
         next_cycle(); #1;
         got = 32'({pc_write, pc_src, alu_src_a, alu_src_b, alu_control});
         want = 32'({(k == 0), 2'd1, 1'b1, 2'd0, 4'b0110});
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL branch%0d got=%h want=%h", k, got, want);
         end
         next_cycle(); #1;
         exp_cnt = exp_cnt + 4'd1;
         got = 32'({mem_req, retired_count});
         want = 32'({1'b1, exp_cnt});
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL branch%0d_retire got=%h want=%h", k, got, want);
         end
      end
   endtask

   task automatic test_jumps;
      opcode = 6'h03; funct = 6'h00; mem_ready = 1'b1;
      #1; next_cycle(); #1; next_cycle(); #1;
      got = 32'({pc_write, pc_src, reg_write, reg_dst_sel, wb_sel});
      want = 32'({1'b1, 2'd2, 1'b1, 2'd2, 2'd2});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL jal got=%h want=%h", got, want);
      end
      next_cycle();
      exp_cnt = exp_cnt + 4'd1;
      opcode = 6'h00; funct = 6'h08;
      #1; next_cycle(); #1; next_cycle(); #1;
      got = 32'({pc_write, pc_src, reg_write});
      want = 32'({1'b1, 2'd3, 1'b0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL jr got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      exp_cnt = exp_cnt + 4'd1;
      got = 32'(retired_count);
      want = 32'(exp_cnt);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL jumps_retire got=%h want=%h", got, want);
      end
   endtask

   task automatic test_imm;
      for (int k = 0; k < 2; k++) begin
         opcode = (k == 0) ? 6'h0d : 6'h0f;
         mem_ready = 1'b1;
         #1; next_cycle(); #1; next_cycle(); #1;
         got = 32'({alu_src_a, alu_src_b, use_zero_extend, alu_control});
         want = (k == 0) ? 32'({1'b1, 2'd2, 1'b1, 4'b0001})
                         : 32'({1'b1, 2'd2, 1'b0, 4'b1000});
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL imm%0d_exec got=%h want=%h", k, got, want);
         end
         next_cycle(); #1;
         got = 32'({reg_write, reg_dst_sel, wb_sel});
         want = 32'({1'b1, 2'd0, (k == 0) ? 2'd0 : 2'd3});
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL imm%0d_wb got=%h want=%h", k, got, want);
         end
         next_cycle();
         exp_cnt = exp_cnt + 4'd1;
      end
   endtask

   task automatic test_illegal;
      opcode = 6'h3f; funct = 6'h00; mem_ready = 1'b1;
      #1;
      got = 32'(illegal);
      want = 32'd0;
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL illegal_fetch got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      got = 32'(illegal);
      want = 32'd1;
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL illegal_decode got=%h want=%h", got, want);
      end
      next_cycle(); #1;
      got = 32'({illegal, mem_req, retired_count});
      want = 32'({1'b0, 1'b1, exp_cnt});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL illegal_after got=%h want=%h", got, want);
      end
   endtask

   task automatic test_sw_reset;
      opcode = 6'h2b; mem_ready = 1'b1;
      #1; next_cycle(); #1; next_cycle(); #1;
      next_cycle();
      mem_ready = 1'b0;
      #1;
      got = 32'({mem_req, mem_we, iord});
      want = 32'({1'b1, 1'b1, 1'b1});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL sw_memwr got=%h want=%h", got, want);
      end
      #1;
      rst = 1'b1;
      exp_cnt = 4'd0;
      #1;
      got = 32'({mem_req, mem_we, retired_count});
      want = 32'd0;
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL sw_async_rst got=%h want=%h", got, want);
      end
      next_cycle();
      next_cycle();
      rst = 1'b0; mem_ready = 1'b1;
      #1;
      got = 32'({mem_req, mem_we, iord});
      want = 32'({1'b1, 1'b0, 1'b0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL sw_refetch got=%h want=%h", got, want);
      end
   endtask

   task automatic test_timeout;
      opcode = 6'h00; funct = 6'h21; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         got = 32'({mem_req, ir_write, mem_error});
         want = 32'({1'b1, 1'b0, 1'b0});
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL tmo_wait%0d got=%h want=%h", i, got, want);
         end
         next_cycle();
      end
      #1;
      got = 32'({mem_error, mem_req});
      want = 32'({1'b1, 1'b0});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL tmo_error got=%h want=%h", got, want);
      end
      mem_ready = 1'b1;
      next_cycle(); next_cycle(); #1;
      got = 32'({mem_error, mem_req, ir_write, pc_write, reg_write});
      want = 32'({1'b1, 4'b0000});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL tmo_absorb got=%h want=%h", got, want);
      end
      do_reset();
      #1;
      got = 32'({mem_error, mem_req});
      want = 32'({1'b0, 1'b1});
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL tmo_clear got=%h want=%h", got, want);
      end
   endtask

   task automatic test_syscall;
      opcode = 6'h00; funct = 6'h0c; mem_ready = 1'b1;
      #1; next_cycle(); #1;
      got = 32'(halt);
      want = 32'd0;
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL sys_decode got=%h want=%h", got, want);
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle(); #1;
         got = 32'({halt, mem_req, pc_write, ir_write, retired_count});
         want = 32'({1'b1, 3'b000, exp_cnt});
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL sys_halt%0d got=%h want=%h", i, got, want);
         end
      end
      do_reset();
   endtask

   task automatic test_wrap;
      opcode = 6'h00; funct = 6'h21; mem_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         #1;
         next_cycle(); next_cycle(); next_cycle(); next_cycle();
         exp_cnt = exp_cnt + 4'd1;
         #1;
         got = 32'(retired_count);
         want = 32'(exp_cnt);
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL wrap_step%0d got=%h want=%h", k, got, want);
         end
      end
      got = 32'(retired_count);
      want = 32'd0;
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL wrap_zero got=%h want=%h", got, want);
      end
   endtask

   initial begin
      exp_cnt = 4'd0;
      test_reset();
      test_addu();
      test_lw_wait();
      test_branch();
      test_jumps();
      test_imm();
      test_illegal();
      test_sw_reset();
      test_timeout();
      test_syscall();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
